// File: rtl/if_fetch_pkg.sv
// Shared defines for the instruction fetch stage: FSM state encodings and
// the opcodes the static branch predictor recognises.
package if_fetch_pkg;

  localparam logic [1:0] StIssue = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

endpackage

// File: rtl/if_fetch_if.sv
// Byte-serial memory read channel between the fetch stage (master) and the
// memory controller (slave). Port suffixes are from the fetch stage's side.
interface if_fetch_if;

  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [7:0]  mem_data_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_valid_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_valid_i,
    output mem_data_i
  );

endinterface

// File: rtl/if_predict.sv
// Static branch predictor: JAL and backward conditional branches are taken,
// everything else (including JALR) falls through to pc + 4.
module if_predict
  import if_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] w_i,
  output logic [31:0] next_pc_o,
  output logic        br_o
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;

  assign imm_j = {{12{w_i[31]}}, w_i[19:12], w_i[20], w_i[30:21], 1'b0};
  assign imm_b = {{20{w_i[31]}}, w_i[7], w_i[30:25], w_i[11:8], 1'b0};

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    br_o      = 1'b0;
    if (w_i[6:0] == OpcJal) begin
      next_pc_o = pc_i + imm_j;
      br_o      = 1'b1;
    end else if ((w_i[6:0] == OpcBranch) && w_i[31]) begin
      next_pc_o = pc_i + imm_b;
      br_o      = 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one request at a time, assembles four bytes
// little-endian, predicts the next PC and holds the result until decode takes it.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               branch_interception_i,
  input  logic [31:0]        branch_target_i,
  if_fetch_if.master         mem_bus,
  output logic               valid_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        inst_o,
  output logic               br_o
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        br_q, br_d;

  logic        slot_free;
  logic        last_byte;
  logic        load;
  logic [31:0] full_word;
  logic [31:0] pred_next_pc;
  logic        pred_br;

  assign slot_free = !valid_q || !stall_i;
  assign last_byte = mem_bus.mem_valid_i && (cnt_q == 2'd3);
  // In HOLD the whole word is parked; in WAIT the 4th byte is still on the bus.
  assign full_word = (state_q == StHold) ? word_q : {mem_bus.mem_data_i, word_q[23:0]};

  if_predict u_predict (
    .pc_i      (fetch_pc_q),
    .w_i       (full_word),
    .next_pc_o (pred_next_pc),
    .br_o      (pred_br)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fetch_pc_d = fetch_pc_q;
    word_d     = word_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    br_d       = br_q;
    load       = 1'b0;

    if (valid_q && !stall_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIssue: begin
        state_d = StWait;
        cnt_d   = 2'd0;
      end
      StWait: begin
        if (mem_bus.mem_valid_i) begin
          if (cnt_q == 2'd3) begin
            if (slot_free) begin
              load = 1'b1;
            end else begin
              word_d  = full_word;
              state_d = StHold;
            end
          end else begin
            word_d[{cnt_q, 3'b000} +: 8] = mem_bus.mem_data_i;
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      StHold: begin
        if (slot_free) begin
          load = 1'b1;
        end
      end
      default: begin
        if (mem_bus.mem_valid_i) begin
          if (cnt_q == 2'd3) begin
            state_d = StIssue;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
    endcase

    if (load && !branch_interception_i) begin
      valid_d    = 1'b1;
      pc_d       = fetch_pc_q;
      inst_d     = full_word;
      br_d       = pred_br;
      fetch_pc_d = pred_next_pc;
      state_d    = StIssue;
    end

    // Redirect wins over everything; bytes still owed must be drained first.
    if (branch_interception_i) begin
      valid_d    = 1'b0;
      fetch_pc_d = branch_target_i;
      if ((state_q == StIssue) ||
          (((state_q == StWait) || (state_q == StDrain)) && !last_byte)) begin
        state_d = StDrain;
      end else begin
        state_d = StIssue;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIssue;
      cnt_q      <= 2'd0;
      fetch_pc_q <= RESET_PC;
      word_q     <= 32'h0;
      valid_q    <= 1'b0;
      pc_q       <= 32'h0;
      inst_q     <= 32'h0;
      br_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fetch_pc_q <= fetch_pc_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      br_q       <= br_d;
    end
  end

  assign mem_bus.mem_req_o  = (state_q == StIssue) && !rst;
  assign mem_bus.mem_addr_o = mem_bus.mem_req_o ? fetch_pc_q : 32'h0;

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign br_o    = br_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a byte-serial memory responder, scoreboard queues for
// expected strobes and consumed instructions, and directed phases.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_interception_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        br_o;

  if_fetch_if mem_bus ();

  if_fetch #(
    .RESET_PC (32'h0)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall_i               (stall_i),
    .branch_interception_i (branch_interception_i),
    .branch_target_i       (branch_target_i),
    .mem_bus               (mem_bus),
    .valid_o               (valid_o),
    .pc_o                  (pc_o),
    .inst_o                (inst_o),
    .br_o                  (br_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
  } fetch_t;

  fetch_t      exp_fetch[$];
  logic [31:0] exp_strobe[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  int          mem_gap = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h00500013;
      32'h04:  return 32'h00100093;
      32'h08:  return 32'h00200113;
      32'h0C:  return 32'h00300193;
      32'h10:  return 32'hFE000EE3;
      32'h20:  return 32'h008000EF;
      32'h28:  return 32'h00000463;
      32'h100: return 32'h00A00213;
      default: return 32'h00000013;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_fetch(input logic [31:0] pc, input logic [31:0] inst, input logic br);
    fetch_t e;
    e.pc   = pc;
    e.inst = inst;
    e.br   = br;
    exp_fetch.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input logic [31:0] addr);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(mem_bus.mem_req_o && (mem_bus.mem_addr_o == addr)) && (n < 60));
    if (n >= 60) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_strobe: no strobe to 0x%08h within 60 cycles", addr);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, {31'b0, valid_o}, 32'h0);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_inst"}, inst_o, 32'h0);
    chk({tag, "_br"}, {31'b0, br_o}, 32'h0);
    chk({tag, "_req"}, {31'b0, mem_bus.mem_req_o}, 32'h0);
    chk({tag, "_addr"}, mem_bus.mem_addr_o, 32'h0);
  endtask

  // Memory controller: 4 bytes per strobe, first after mem_lat cycles, then every mem_gap+1.
  initial begin
    int          owed;
    int          idx;
    int          wait_cnt;
    logic [31:0] base;
    logic [31:0] w;
    owed = 0;
    idx = 0;
    wait_cnt = 0;
    base = 32'h0;
    mem_bus.mem_valid_i = 1'b0;
    mem_bus.mem_data_i  = 8'h0;
    forever begin
      @(negedge clk);
      mem_bus.mem_valid_i = 1'b0;
      if (rst) begin
        owed = 0;
      end else begin
        if (owed > 0) begin
          if (wait_cnt > 0) begin
            wait_cnt--;
          end else begin
            w = mem_word(base);
            mem_bus.mem_data_i  = w[8*idx +: 8];
            mem_bus.mem_valid_i = 1'b1;
            idx++;
            owed--;
            wait_cnt = mem_gap;
          end
        end
        if (mem_bus.mem_req_o) begin
          chk("strobe_while_owed", owed, 0);
          owed = 4;
          idx = 0;
          base = mem_bus.mem_addr_o;
          wait_cnt = mem_lat - 1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a strobe fires or decode consumes.
  initial begin
    fetch_t      e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_bus.mem_req_o) begin
          if (exp_strobe.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_unexpected: addr 0x%08h, expected no strobe",
                     mem_bus.mem_addr_o);
          end else begin
            a = exp_strobe.pop_front();
            chk("strobe_addr", mem_bus.mem_addr_o, a);
          end
        end
        if (valid_o && !stall_i) begin
          if (exp_fetch.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL fetch_unexpected: pc 0x%08h inst 0x%08h, expected none", pc_o, inst_o);
          end else begin
            e = exp_fetch.pop_front();
            chk("fetch_pc", pc_o, e.pc);
            chk("fetch_inst", inst_o, e.inst);
            chk("fetch_br", {31'b0, br_o}, {31'b0, e.br});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset, then first fetch and a second fetch parked in HOLD under stall.
    rst = 1'b1;
    stall_i = 1'b1;
    repeat (3) step();
    chk_reset_values("reset");
    push_fetch(32'h0, 32'h00500013, 1'b0);
    exp_strobe.push_back(32'h0);
    exp_strobe.push_back(32'h4);
    rst = 1'b0;
    #1;
    chk("first_strobe", {31'b0, mem_bus.mem_req_o}, 32'h1);
    n = 0;
    do begin
      step();
      n++;
    end while (!valid_o && (n < 20));
    chk("first_fetch_latency", n, 5);
    chk("first_pc", pc_o, 32'h0);
    chk("first_inst", inst_o, 32'h00500013);
    chk("first_br", {31'b0, br_o}, 32'h0);
    repeat (12) step();
    chk("stall_valid", {31'b0, valid_o}, 32'h1);
    chk("stall_pc", pc_o, 32'h0);
    chk("stall_inst", inst_o, 32'h00500013);
    chk("hold_no_strobe", {31'b0, mem_bus.mem_req_o}, 32'h0);

    // Release stall: held word appears next cycle with a strobe to 8.
    push_fetch(32'h4, 32'h00100093, 1'b0);
    push_fetch(32'h8, 32'h00200113, 1'b0);
    push_fetch(32'hC, 32'h00300193, 1'b0);
    exp_strobe.push_back(32'h8);
    exp_strobe.push_back(32'hC);
    exp_strobe.push_back(32'h10);
    stall_i = 1'b0;
    step();
    chk("release_valid", {31'b0, valid_o}, 32'h1);
    chk("release_pc", pc_o, 32'h4);
    chk("release_inst", inst_o, 32'h00100093);
    chk("release_strobe", {31'b0, mem_bus.mem_req_o}, 32'h1);

    // Backward branch at 0x10, held under stall, then redirected mid-request.
    wait_strobe(32'h10);
    step();
    stall_i = 1'b1;
    exp_strobe.push_back(32'hC);
    repeat (4) step();
    chk("beq_valid", {31'b0, valid_o}, 32'h1);
    chk("beq_pc", pc_o, 32'h10);
    chk("beq_inst", inst_o, 32'hFE000EE3);
    chk("beq_br", {31'b0, br_o}, 32'h1);
    chk("beq_next_req", {31'b0, mem_bus.mem_req_o}, 32'h1);
    chk("beq_next_addr", mem_bus.mem_addr_o, 32'hC);
    repeat (3) step();
    branch_interception_i = 1'b1;
    branch_target_i = 32'h100;
    step();
    branch_interception_i = 1'b0;
    chk("redir_valid", {31'b0, valid_o}, 32'h0);
    chk("drain_no_req", {31'b0, mem_bus.mem_req_o}, 32'h0);
    exp_strobe.push_back(32'h100);
    exp_strobe.push_back(32'h104);
    step();
    chk("drain_done_req", {31'b0, mem_bus.mem_req_o}, 32'h1);
    chk("drain_done_addr", mem_bus.mem_addr_o, 32'h100);

    // Redirect on the 4th-byte edge while stalled: no HOLD, immediate strobe.
    repeat (5) step();
    chk("t100_valid", {31'b0, valid_o}, 32'h1);
    chk("t100_pc", pc_o, 32'h100);
    chk("t100_inst", inst_o, 32'h00A00213);
    repeat (4) step();
    branch_interception_i = 1'b1;
    branch_target_i = 32'h100;
    exp_strobe.push_back(32'h100);
    step();
    branch_interception_i = 1'b0;
    chk("redir4_valid", {31'b0, valid_o}, 32'h0);
    chk("redir4_req", {31'b0, mem_bus.mem_req_o}, 32'h1);
    chk("redir4_addr", mem_bus.mem_addr_o, 32'h100);

    // Redirect in the strobe cycle itself, with slow gapped memory.
    branch_interception_i = 1'b1;
    branch_target_i = 32'h20;
    stall_i = 1'b0;
    mem_lat = 2;
    mem_gap = 1;
    exp_strobe.push_back(32'h20);
    exp_strobe.push_back(32'h28);
    exp_strobe.push_back(32'h2C);
    exp_strobe.push_back(32'h30);
    push_fetch(32'h20, 32'h008000EF, 1'b1);
    push_fetch(32'h28, 32'h00000463, 1'b0);
    push_fetch(32'h2C, 32'h00000013, 1'b0);
    step();
    branch_interception_i = 1'b0;
    n = 1;
    while (!mem_bus.mem_req_o && (n < 30)) begin
      step();
      n++;
    end
    chk("issue_redirect_drain_cycles", n, 9);
    chk("issue_redirect_addr", mem_bus.mem_addr_o, 32'h20);

    // Reset in the middle of a request.
    wait_strobe(32'h30);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk_reset_values("midreset");
    exp_strobe.push_back(32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("restart_req", {31'b0, mem_bus.mem_req_o}, 32'h1);
    chk("restart_addr", mem_bus.mem_addr_o, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("strobes_left", exp_strobe.size(), 0);
    chk("fetches_left", exp_fetch.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
